// File: rtl/dmem_rr_arbiter.sv
// dmem_rr_arbiter
// Shares the single-port data memory between four cores. One core is granted
// at a time by rotating priority; the granted access is issued to memory and
// completed with a one-cycle ack pulse (plus load data) back to that core.
// All outputs come straight from flops: the next value of each output is
// computed from the next state and the captured request.

module dmem_rr_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [3:0]        req_i,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [ADDR_W-1:0] addr2_i,
    input  logic [ADDR_W-1:0] addr3_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic [DATA_W-1:0] wdata2_i,
    input  logic [DATA_W-1:0] wdata3_i,
    output logic [3:0]        ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    // Wide enough to hold RD_LAT up to 4.
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    // Rotating-priority pick: bit 2 = found, bits 1:0 = winning index.
    // Scanning from the farthest offset down lets the nearest one (base) win.
    function automatic logic [2:0] rr_pick(input logic [3:0] vec, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = base + 2'(i);
            res = vec[idx] ? {1'b1, idx} : res;
        end
        return res;
    endfunction

    // One-hot decode of a core index.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Control state
    state_e            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [3:0]        mask_q, mask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Captured transaction of the granted core
    logic [1:0]        g_q, g_d;
    logic              g_we_q, g_we_d;
    logic [ADDR_W-1:0] g_addr_q, g_addr_d;
    logic [DATA_W-1:0] g_wdata_q, g_wdata_d;

    // Registered outputs
    logic [3:0]        ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;

    // Arbitration result and winner's request fields
    logic [2:0]        pick;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;

    // A core just acked is masked out for exactly the following IDLE cycle.
    assign pick = rr_pick(req_i & ~mask_q, ptr_q);

    // Route the winning core's address, data and direction to the capture path.
    always_comb begin
        sel_addr  = addr0_i;
        sel_wdata = wdata0_i;
        sel_we    = we_i[pick[1:0]];
        case (pick[1:0])
            2'd0: begin
                sel_addr  = addr0_i;
                sel_wdata = wdata0_i;
            end
            2'd1: begin
                sel_addr  = addr1_i;
                sel_wdata = wdata1_i;
            end
            2'd2: begin
                sel_addr  = addr2_i;
                sel_wdata = wdata2_i;
            end
            2'd3: begin
                sel_addr  = addr3_i;
                sel_wdata = wdata3_i;
            end
            default: begin
                sel_addr  = addr0_i;
                sel_wdata = wdata0_i;
            end
        endcase
    end

    // Next-state logic of the access sequencer and the output pre-computation.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
        g_d       = g_q;
        g_we_d    = g_we_q;
        g_addr_d  = g_addr_q;
        g_wdata_d = g_wdata_q;
        rdata_d   = rdata_q;

        case (state_q)
            ST_IDLE: begin
                // The suppression of the last winner lasts one IDLE cycle only.
                mask_d = 4'b0000;
                if (pick[2]) begin
                    g_d       = pick[1:0];
                    g_we_d    = sel_we;
                    g_addr_d  = sel_addr;
                    g_wdata_d = sel_wdata;
                    state_d   = ST_ISSUE;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (g_we_q) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Read data is valid in the last WAIT cycle (counter at 1).
                if (cnt_q == 3'd1) begin
                    rdata_d = mem_rdata_i;
                    cnt_d   = 3'd0;
                    state_d = ST_ACK;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                    state_d = ST_WAIT;
                end
            end
            ST_ACK: begin
                ptr_d   = g_q + 2'd1;
                mask_d  = onehot4(g_q);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs for the cycle in which state_d becomes current.
        busy_d      = (state_d != ST_IDLE);
        ack_d       = (state_d == ST_ACK) ? onehot4(g_d) : 4'b0000;
        mem_we_d    = (state_d == ST_ISSUE) && g_we_d;
        mem_re_d    = (state_d == ST_ISSUE) && !g_we_d;
        mem_addr_d  = (state_d != ST_IDLE) ? g_addr_d  : {ADDR_W{1'b0}};
        mem_wdata_d = (state_d != ST_IDLE) ? g_wdata_d : {DATA_W{1'b0}};
    end

    // State, captured request and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd0;
            mask_q      <= 4'b0000;
            cnt_q       <= 3'd0;
            g_q         <= 2'd0;
            g_we_q      <= 1'b0;
            g_addr_q    <= {ADDR_W{1'b0}};
            g_wdata_q   <= {DATA_W{1'b0}};
            ack_q       <= 4'b0000;
            rdata_q     <= {DATA_W{1'b0}};
            busy_q      <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            g_q         <= g_d;
            g_we_q      <= g_we_d;
            g_addr_q    <= g_addr_d;
            g_wdata_q   <= g_wdata_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
        end
    end

    assign ack_o       = ack_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = busy_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o    = mem_we_q;
    assign mem_re_o    = mem_re_q;

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Bench for dmem_rr_arbiter: three instances (RD_LAT = 1, 3, 4), each with its
// own memory model and a transaction-level reference model checked every cycle,
// plus directed checks with hand-computed values.

module tb_dmem_rr_arbiter;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [NI];
    logic [3:0]  req       [NI];
    logic [3:0]  we        [NI];
    logic [15:0] addr      [NI][4];
    logic [15:0] wdata     [NI][4];
    logic [3:0]  ack       [NI];
    logic [15:0] rdata     [NI];
    logic        busy      [NI];
    logic [15:0] mem_addr  [NI];
    logic [15:0] mem_wdata [NI];
    logic        mem_we    [NI];
    logic        mem_re    [NI];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (u%0d) got=%0h expected=%0h at t=%0t", name, k, got, exp, $time);
        end
    endtask

    // Contents of a never-written memory word.
    function automatic logic [15:0] init_val(input logic [15:0] a);
        return 16'h5A00 | {8'h00, a[7:0]};
    endfunction

    for (genvar k = 0; k < NI; k++) begin : g_u
        localparam int LAT = (k == 0) ? 1 : ((k == 1) ? 3 : 4);

        // memory model: read data appears LAT cycles after the mem_re cycle
        logic [15:0] ram  [256];
        bit          wrv  [256];
        logic [15:0] pipe [4];

        always @(posedge clk) begin
            if (mem_we[k] === 1'b1) begin
                ram[mem_addr[k][7:0]] <= mem_wdata[k];
                wrv[mem_addr[k][7:0]] <= 1'b1;
            end
            if (mem_re[k] === 1'b1)
                pipe[0] <= wrv[mem_addr[k][7:0]] ? ram[mem_addr[k][7:0]] : init_val(mem_addr[k]);
            else
                pipe[0] <= 16'hDEAD;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
            pipe[3] <= pipe[2];
        end

        dmem_rr_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(LAT)) u_dut (
            .clk_i      (clk),
            .reset_i    (rst[k]),
            .req_i      (req[k]),
            .we_i       (we[k]),
            .addr0_i    (addr[k][0]),
            .addr1_i    (addr[k][1]),
            .addr2_i    (addr[k][2]),
            .addr3_i    (addr[k][3]),
            .wdata0_i   (wdata[k][0]),
            .wdata1_i   (wdata[k][1]),
            .wdata2_i   (wdata[k][2]),
            .wdata3_i   (wdata[k][3]),
            .ack_o      (ack[k]),
            .rdata_o    (rdata[k]),
            .busy_o     (busy[k]),
            .mem_addr_o (mem_addr[k]),
            .mem_wdata_o(mem_wdata[k]),
            .mem_we_o   (mem_we[k]),
            .mem_re_o   (mem_re[k]),
            .mem_rdata_i(pipe[LAT-1])
        );

        // Reference model: a granted transaction occupies t = 1..dur cycles,
        // dur = 2 for a store and LAT + 2 for a load; ack in its last cycle.
        bit          started = 1'b0;
        bit          act = 1'b0;
        bit          cw = 1'b0;
        bit          mask_en = 1'b0;
        int          t = 0;
        int          cur = 0;
        int          ptr = 0;
        int          mask_g = 0;
        int          dur = 0;
        logic [15:0] ca = 16'h0;
        logic [15:0] cd = 16'h0;
        logic [15:0] rd_e = 16'h0;
        logic [15:0] mm  [256];
        bit          mmv [256];
        logic [3:0]  eff;
        logic [3:0]  e_ack;

        initial forever begin
            @(posedge clk);
            if (rst[k]) begin
                started = 1'b1;
                act = 1'b0;
                ptr = 0;
                mask_en = 1'b0;
                rd_e = 16'h0000;
            end else if (!act) begin
                eff = req[k];
                if (mask_en) eff[mask_g] = 1'b0;
                mask_en = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (!act && eff[(ptr + i) % 4]) begin
                        act = 1'b1;
                        cur = (ptr + i) % 4;
                        t = 1;
                        cw = we[k][cur];
                        ca = addr[k][cur];
                        cd = wdata[k][cur];
                    end
                end
            end else begin
                dur = cw ? 2 : LAT + 2;
                if (t == dur) begin
                    act = 1'b0;
                    ptr = (cur + 1) % 4;
                    mask_en = 1'b1;
                    mask_g = cur;
                end else begin
                    if (t == 1 && cw) begin
                        mm[ca[7:0]] = cd;
                        mmv[ca[7:0]] = 1'b1;
                    end
                    if (t == dur - 1 && !cw)
                        rd_e = mmv[ca[7:0]] ? mm[ca[7:0]] : init_val(ca);
                    t++;
                end
            end
            #1;
            if (started) begin
                dur = cw ? 2 : LAT + 2;
                e_ack = (act && t == dur) ? (4'b0001 << cur) : 4'b0000;
                check("m_busy", k, busy[k], act);
                check("m_mem_we", k, mem_we[k], act && t == 1 && cw);
                check("m_mem_re", k, mem_re[k], act && t == 1 && !cw);
                check("m_ack", k, ack[k], e_ack);
                check("m_rdata", k, rdata[k], rd_e);
                if (!act) begin
                    check("m_mem_addr_idle", k, mem_addr[k], 16'h0000);
                    check("m_mem_wdata_idle", k, mem_wdata[k], 16'h0000);
                end else if (t < dur) begin
                    check("m_mem_addr", k, mem_addr[k], ca);
                    if (cw && t == 1) check("m_mem_wdata", k, mem_wdata[k], cd);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    logic [3:0] got_ack [$];
    int         got_n   [$];
    logic [3:0] exp_seq [5];
    logic [3:0] a_i;

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1;
            req[k] = 4'b0000;
            we[k]  = 4'b0000;
            for (int c = 0; c < 4; c++) begin
                addr[k][c]  = 16'h0000;
                wdata[k][c] = 16'h0000;
            end
        end
        repeat (3) tick();
        // reset state
        check("rst_ack", 0, ack[0], 4'b0000);
        check("rst_busy", 0, busy[0], 1'b0);
        check("rst_mem_addr", 0, mem_addr[0], 16'h0000);
        check("rst_rdata", 0, rdata[0], 16'h0000);
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        tick();

        // store from core 1
        req[0] = 4'b0001; we[0] = 4'b0001; addr[0][0] = 16'h0010; wdata[0][0] = 16'hBEEF;
        tick();
        check("st_mem_we", 0, mem_we[0], 1'b1);
        check("st_mem_addr", 0, mem_addr[0], 16'h0010);
        check("st_mem_wdata", 0, mem_wdata[0], 16'hBEEF);
        check("st_ack_early", 0, ack[0], 4'b0000);
        tick();
        check("st_ack", 0, ack[0], 4'b0001);
        req[0] = 4'b0000;
        tick();
        check("st_busy_low", 0, busy[0], 1'b0);

        // load from core 3 of the stored word
        req[0] = 4'b0100; we[0] = 4'b0000; addr[0][2] = 16'h0010;
        tick();
        check("ld_mem_re", 0, mem_re[0], 1'b1);
        check("ld_mem_addr", 0, mem_addr[0], 16'h0010);
        tick();
        tick();
        check("ld_ack", 0, ack[0], 4'b0100);
        check("ld_rdata", 0, rdata[0], 16'hBEEF);
        req[0] = 4'b0000;
        tick();

        // all four storing continuously from reset
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            addr[0][c]  = 16'h0040 + 16'(c);
            wdata[0][c] = 16'h1000 + 16'(c);
        end
        we[0] = 4'b1111; req[0] = 4'b1111;
        for (int n = 0; n < 14; n++) begin
            tick();
            if (ack[0] != 4'b0000) begin
                got_ack.push_back(ack[0]);
                got_n.push_back(n);
            end
        end
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        check("rr_count", 0, got_ack.size(), 5);
        for (int i = 0; i < 5; i++) begin
            a_i = (i < got_ack.size()) ? got_ack[i] : 4'b0000;
            check("rr_order", 0, a_i, exp_seq[i]);
            if (i > 0)
                check("rr_spacing", 0, (i < got_n.size()) ? got_n[i] - got_n[i-1] : -1, 3);
        end

        // core 2 holds req one cycle past its ack while core 4 requests
        req[0] = 4'b1010;
        tick(); tick(); tick();
        check("hold_ack_c2", 0, ack[0], 4'b0010);
        tick();
        tick();
        req[0] = 4'b1000;
        check("hold_mem_addr_c4", 0, mem_addr[0], 16'h0043);
        tick();
        check("hold_ack_c4", 0, ack[0], 4'b1000);
        tick();
        tick();
        check("mask_no_regrant", 0, busy[0], 1'b0);
        req[0] = 4'b0000;
        tick();

        // RD_LAT=3: reset during WAIT of a load
        req[1] = 4'b0010; we[1] = 4'b0010; addr[1][1] = 16'h0050; wdata[1][1] = 16'h2222;
        tick();
        tick();
        check("r3_st_ack", 1, ack[1], 4'b0010);
        req[1] = 4'b0000;
        tick();
        req[1] = 4'b0001; we[1] = 4'b0000; addr[1][0] = 16'h0020;
        tick();
        check("r3_mem_re", 1, mem_re[1], 1'b1);
        tick();
        rst[1] = 1'b1; req[1] = 4'b0000;
        tick();
        rst[1] = 1'b0;
        check("r3_rst_ack", 1, ack[1], 4'b0000);
        check("r3_rst_busy", 1, busy[1], 1'b0);
        check("r3_rst_mem_addr", 1, mem_addr[1], 16'h0000);
        check("r3_rst_mem_wdata", 1, mem_wdata[1], 16'h0000);
        check("r3_rst_mem_we", 1, mem_we[1], 1'b0);
        check("r3_rst_mem_re", 1, mem_re[1], 1'b0);
        check("r3_rst_rdata", 1, rdata[1], 16'h0000);
        for (int n = 0; n < 4; n++) begin
            tick();
            check("r3_no_ack", 1, ack[1], 4'b0000);
        end
        req[1] = 4'b1001; we[1] = 4'b1001;
        addr[1][0] = 16'h0021; wdata[1][0] = 16'h3333;
        addr[1][3] = 16'h0060; wdata[1][3] = 16'h4444;
        tick();
        tick();
        check("r3_ptr0_ack_c1", 1, ack[1], 4'b0001);
        req[1] = 4'b1000;
        tick(); tick(); tick();
        check("r3_ack_c4", 1, ack[1], 4'b1000);
        req[1] = 4'b0000;
        tick();

        // RD_LAT=4: single load from core 2
        req[2] = 4'b0010; we[2] = 4'b0000; addr[2][1] = 16'h0030;
        tick();
        check("r4_mem_re", 2, mem_re[2], 1'b1);
        check("r4_mem_addr_t1", 2, mem_addr[2], 16'h0030);
        for (int n = 2; n <= 5; n++) begin
            tick();
            check("r4_mem_addr_hold", 2, mem_addr[2], 16'h0030);
            check("r4_ack_early", 2, ack[2], 4'b0000);
        end
        tick();
        check("r4_ack", 2, ack[2], 4'b0010);
        check("r4_rdata", 2, rdata[2], 16'h5A30);
        req[2] = 4'b0000;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
